// File: rtl/idct_1d_pkg.sv
// Shared definitions for the 8-point 1-D inverse DCT: widths, FSM encoding and
// the Q12 cosine basis table C[k][n] = round(4096 * c(k)/2 * cos((2n+1)k*pi/16)).
package idct_1d_pkg;

  localparam int CW_DEF   = 20;
  localparam int OW_DEF   = 8;
  localparam int FRAC_DEF = 12;
  localparam int TAB_W    = 14;
  localparam int ACC_W    = 40;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

  typedef logic signed [TAB_W-1:0] coef_t;

  // Row index k is the coefficient (frequency), column index n the output sample.
  localparam int COS_TAB [8][8] = '{
    '{ 1448,  1448,  1448,  1448,  1448,  1448,  1448,  1448},
    '{ 2009,  1703,  1138,   400,  -400, -1138, -1703, -2009},
    '{ 1892,   784,  -784, -1892, -1892,  -784,   784,  1892},
    '{ 1703,  -400, -2009, -1138,  1138,  2009,   400, -1703},
    '{ 1448, -1448, -1448,  1448,  1448, -1448, -1448,  1448},
    '{ 1138, -2009,   400,  1703, -1703,  -400,  2009, -1138},
    '{  784, -1892,  1892,  -784,  -784,  1892, -1892,   784},
    '{  400, -1138,  1703, -2009,  2009, -1703,  1138,  -400}
  };

endpackage

// File: rtl/idct_coef_rom.sv
// Combinational cosine ROM: for output sample index n, returns C[0..7][n].
// Kept standalone so row and column stages of a 2-D IDCT can share it.
module idct_coef_rom
  import idct_1d_pkg::*;
(
  input  logic [2:0] n,
  output coef_t      c [8]
);

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      c[k] = coef_t'(COS_TAB[k][n]);
    end
  end

endmodule

// File: rtl/idct_1d.sv
// 8-point 1-D inverse DCT: latches one coefficient vector, then produces one
// rounded, saturated output sample per clock through 8 MACs and an adder tree.
module idct_1d
  import idct_1d_pkg::*;
#(
  parameter int CW       = CW_DEF,
  parameter int OW       = OW_DEF,
  parameter int FRAC     = FRAC_DEF,
  parameter int IN_SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic signed [CW-1:0] X0,
  input  logic signed [CW-1:0] X1,
  input  logic signed [CW-1:0] X2,
  input  logic signed [CW-1:0] X3,
  input  logic signed [CW-1:0] X4,
  input  logic signed [CW-1:0] X5,
  input  logic signed [CW-1:0] X6,
  input  logic signed [CW-1:0] X7,
  output logic                 r_valid,
  output logic signed [OW-1:0] x0,
  output logic signed [OW-1:0] x1,
  output logic signed [OW-1:0] x2,
  output logic signed [OW-1:0] x3,
  output logic signed [OW-1:0] x4,
  output logic signed [OW-1:0] x5,
  output logic signed [OW-1:0] x6,
  output logic signed [OW-1:0] x7
);

  localparam int SH = FRAC + IN_SHIFT;
  localparam int PW = CW + TAB_W;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(64'sd1 <<< (SH - 1));
  localparam logic signed [ACC_W-1:0] OMAX = ACC_W'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] OMIN = ACC_W'(-(64'sd1 <<< (OW - 1)));

  state_t                  state, state_nxt;
  logic [2:0]              n_cnt;
  logic                    accept;
  logic signed [CW-1:0]    xin [8];
  logic signed [CW-1:0]    xreg_p0 [8];
  coef_t                   c [8];
  logic signed [PW-1:0]    prod [8];
  logic signed [ACC_W-1:0] acc;
  logic signed [OW-1:0]    y_sat;
  logic signed [OW-1:0]    y_p1 [8];

  // Round half toward +inf, then drop the fractional (and scaling) bits.
  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
    return (a + HALF) >>> SH;
  endfunction

  function automatic logic signed [OW-1:0] saturate(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a;
    if (a > OMAX) s = OMAX;
    else if (a < OMIN) s = OMIN;
    return s[OW-1:0];
  endfunction

  assign xin[0] = X0;
  assign xin[1] = X1;
  assign xin[2] = X2;
  assign xin[3] = X3;
  assign xin[4] = X4;
  assign xin[5] = X5;
  assign xin[6] = X6;
  assign xin[7] = X7;

  assign accept = i_valid & i_ready;

  idct_coef_rom u_rom (
    .n (n_cnt),
    .c (c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    i_ready   = 1'b0;
    r_valid   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        i_ready = 1'b1;
        if (i_valid) state_nxt = ST_CALC;
      end
      ST_CALC: if (n_cnt == 3'd7) state_nxt = ST_DONE;
      ST_DONE: begin
        r_valid   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0 -> p1: dot product of latched coefficients with basis column n.
  always_comb begin
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      prod[k] = PW'(xreg_p0[k]) * PW'(c[k]);
      acc     = acc + ACC_W'(prod[k]);
    end
    y_sat = saturate(round_shift(acc));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_cnt <= 3'd0;
      for (int k = 0; k < 8; k++) begin
        xreg_p0[k] <= '0;
        y_p1[k]    <= '0;
      end
    end else begin
      if (accept) begin
        n_cnt <= 3'd0;
        for (int k = 0; k < 8; k++) xreg_p0[k] <= xin[k];
      end
      if (state == ST_CALC) begin
        y_p1[n_cnt] <= y_sat;
        n_cnt       <= n_cnt + 3'd1;
      end
    end
  end

  assign x0 = y_p1[0];
  assign x1 = y_p1[1];
  assign x2 = y_p1[2];
  assign x3 = y_p1[3];
  assign x4 = y_p1[4];
  assign x5 = y_p1[5];
  assign x6 = y_p1[6];
  assign x7 = y_p1[7];

endmodule

// File: tb/tb_idct_1d.sv
// Randomized bench for idct_1d against a real-arithmetic inverse DCT model.
`timescale 1ns/1ps
module tb_idct_1d;

  localparam real PI = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_valid;
  logic               i_ready;
  logic               r_valid;
  logic signed [19:0] X [8];
  logic signed [7:0]  y [8];

  int n_tests = 0;
  int n_fail  = 0;

  idct_1d dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
    .X0(X[0]), .X1(X[1]), .X2(X[2]), .X3(X[3]),
    .X4(X[4]), .X5(X[5]), .X6(X[6]), .X7(X[7]),
    .r_valid(r_valid),
    .x0(y[0]), .x1(y[1]), .x2(y[2]), .x3(y[3]),
    .x4(y[4]), .x5(y[5]), .x6(y[6]), .x7(y[7])
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Basis table and reference sample, from the closed-form cosine definition.
  int tab [8][8];
  initial begin
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++) begin
        real ck, v;
        ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        v  = 4096.0 * ck / 2.0 * $cos(real'((2 * n + 1) * k) * PI / 16.0);
        tab[k][n] = int'($floor(v + 0.5));
      end
  end

  function automatic int ref_sample(input int xv[8], input int n);
    real s, r;
    s = 0.0;
    for (int k = 0; k < 8; k++) s = s + real'(tab[k][n]) * real'(xv[k]);
    r = $floor((s + 2048.0) / 4096.0);
    if (r > 127.0) r = 127.0;
    if (r < -128.0) r = -128.0;
    return int'(r);
  endfunction

  // Transaction model: accept whenever idle, result 8 edges later, idle after 9.
  bit busy = 1'b0;
  int age  = 0;
  int exp_y [8];
  always @(posedge clk or posedge rst) begin
    if (rst) busy = 1'b0;
    else if (!busy) begin
      if (i_valid) begin
        int v [8];
        for (int k = 0; k < 8; k++) v[k] = int'(X[k]);
        for (int n = 0; n < 8; n++) exp_y[n] = ref_sample(v, n);
        busy = 1'b1;
        age  = 0;
      end
    end else begin
      age++;
      if (age == 9) busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rst_i_ready", int'(i_ready), 1);
      check("rst_r_valid", int'(r_valid), 0);
      for (int n = 0; n < 8; n++) check("rst_x", int'(y[n]), 0);
    end else begin
      check("i_ready", int'(i_ready), int'(!busy));
      check("r_valid", int'(r_valid), int'(busy && age == 8));
      if (busy && age == 8)
        for (int n = 0; n < 8; n++) check($sformatf("x%0d", n), int'(y[n]), exp_y[n]);
    end
  end

  task automatic send(input int v[8]);
    int t;
    t = 0;
    @(negedge clk);
    while (!i_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!i_ready) check("ready_timeout", 0, 1);
    for (int k = 0; k < 8; k++) X[k] = 20'(v[k]);
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_result(output bit got);
    got = 1'b0;
    for (int t = 0; t < 12; t++) begin
      if (r_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) check("result_timeout", 0, 1);
  endtask

  task automatic run_lit(input string nm, input int v[8], input int e[8]);
    bit got;
    send(v);
    wait_result(got);
    if (got) for (int n = 0; n < 8; n++) check(nm, int'(y[n]), e[n]);
    @(negedge clk);
    check({nm, "_strobe_end"}, int'(r_valid), 0);
  endtask

  initial begin
    int v [8];
    int e [8];
    int orig [8];
    bit got;
    rst = 1'b1;
    i_valid = 1'b0;
    for (int k = 0; k < 8; k++) X[k] = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Pin the model to hand-derived values.
    check("tab00", tab[0][0], 1448);
    check("tab10", tab[1][0], 2009);
    v = '{181, 0, 0, 0, 0, 0, 0, 0};
    check("model_dc", ref_sample(v, 3), 64);
    v = '{0, 256, 0, 0, 0, 0, 0, 0};
    check("model_ac0", ref_sample(v, 0), 126);
    check("model_ac7", ref_sample(v, 7), -126);

    v = '{181, 0, 0, 0, 0, 0, 0, 0};
    e = '{64, 64, 64, 64, 64, 64, 64, 64};
    run_lit("dc", v, e);
    v = '{0, 256, 0, 0, 0, 0, 0, 0};
    e = '{126, 106, 71, 25, -25, -71, -106, -126};
    run_lit("ac1", v, e);
    v = '{1000, 0, 0, 0, 0, 0, 0, 0};
    e = '{127, 127, 127, 127, 127, 127, 127, 127};
    run_lit("sat_pos", v, e);
    v = '{-1000, 0, 0, 0, 0, 0, 0, 0};
    e = '{-128, -128, -128, -128, -128, -128, -128, -128};
    run_lit("sat_neg", v, e);
    v = '{0, 0, 0, 0, 0, 0, 0, 0};
    e = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_lit("zero", v, e);
    v = '{-524288, -524288, -524288, -524288, -524288, -524288, -524288, -524288};
    send(v);
    wait_result(got);
    v = '{-524288, 0, 0, 0, 0, 0, 0, 0};
    e = '{-128, -128, -128, -128, -128, -128, -128, -128};
    run_lit("most_neg", v, e);

    // i_valid held high with a fresh vector every cycle.
    i_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      for (int k = 0; k < 8; k++) X[k] = 20'($urandom_range(0, 600) - 300);
      @(negedge clk);
    end
    i_valid = 1'b0;
    repeat (12) @(negedge clk);

    // Random vectors, mixed magnitudes and idle gaps.
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 8; k++)
        v[k] = (t % 3 == 0) ? int'($urandom_range(0, 1048575)) - 524288
                            : int'($urandom_range(0, 800)) - 400;
      send(v);
      repeat ($urandom_range(8, 14)) @(negedge clk);
    end

    // Reset in the middle of a computation.
    v = '{300, 50, -20, 0, 7, 0, 0, 1};
    send(v);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_i_ready", int'(i_ready), 1);
    check("midrst_x0", int'(y[0]), 0);
    check("midrst_x3", int'(y[3]), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (r_valid) got = 1'b1;
    end
    check("midrst_no_rvalid", int'(got), 0);
    v = '{181, 0, 0, 0, 0, 0, 0, 0};
    e = '{64, 64, 64, 64, 64, 64, 64, 64};
    run_lit("after_rst", v, e);

    // Round trip through a real-valued forward DCT with matching scaling.
    orig = '{64, 32, -45, 55, 64, -10, 15, 78};
    for (int k = 0; k < 8; k++) begin
      real s, ck;
      ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
      s  = 0.0;
      for (int n = 0; n < 8; n++)
        s = s + real'(orig[n]) * $cos(real'((2 * n + 1) * k) * PI / 16.0);
      v[k] = int'($floor(ck / 2.0 * s + 0.5));
    end
    send(v);
    wait_result(got);
    if (got)
      for (int n = 0; n < 8; n++) begin
        int d;
        d = int'(y[n]) - orig[n];
        check($sformatf("roundtrip_x%0d_err_le1", n), int'(d <= 1 && d >= -1), 1);
      end
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/idct_1d.md
Name: idct_1d

Overview:
- 8-point 1-D inverse DCT; the return path of the forward 1-D DCT.
- Accepts one vector of eight signed 20-bit coefficients X0..X7 and produces eight signed 8-bit samples x0..x7.
- Coefficient format matches the forward DCT output.
- Sequential architecture: 8 parallel multipliers plus an adder tree produce one output sample per clock over 8 clocks, with a valid/ready input handshake and a one-cycle result strobe.

Parameters:
- CW, 20, input coefficient width (signed).
- OW, 8, output sample width (signed, saturated).
- FRAC, 12, fractional bits of the cosine table.
- IN_SHIFT, 0, extra right shift applied to undo forward-DCT scaling.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  coefficient vector X0..X7 valid.
- i_ready  out  1  block can accept a vector.
- X0..X7  in  CW each  signed DCT coefficients, sampled on the accept edge.
- r_valid  out  1  one-cycle strobe: x0..x7 hold a new result.
- x0..x7  out  OW each  signed reconstructed samples.

Behaviour:
- Reset (async, rst=1): state IDLE, n counter 0, r_valid 0, x0..x7 0, coefficient registers 0. Mid-operation reset aborts the computation; no r_valid follows.
- i_ready is 1 exactly when state is IDLE (decoded from state). Accept edge E0 occurs when i_valid & i_ready; X0..X7 are latched into internal registers. Inputs are ignored at all other times, including i_valid held high during CALC/DONE.
- IDLE: on accept -> CALC, n=0.
- CALC: each cycle computes x[n] = sum over k of C[k][n]*Xreg[k]. Edge En+1 writes output register x_n and increments n. After n=7 is written (edge E8) -> DONE.
- DONE: r_valid=1 for this single cycle -> IDLE at next edge, where r_valid returns to 0.
- Latency: r_valid is high in the cycle following E8, 8 clocks after the accept edge. Minimum spacing between accepts is 10 clocks.
- x0..x7 update one per cycle during CALC; they are guaranteed coherent only while r_valid=1. They hold their value until the next CALC overwrites them.
- Table: C[k][n] = round(2^FRAC * c(k)/2 * cos((2n+1)k*pi/16)), with c(0)=1/sqrt(2) and c(k>0)=1. Stored as signed 14-bit; C[0][n]=1448, C[1][0]=2009.
- Arithmetic: products are CW+14 bits. Accumulate in 40-bit signed (no overflow possible).
- Rounding: add 2^(FRAC+IN_SHIFT-1), then arithmetic shift right by FRAC+IN_SHIFT (round half toward +inf).
- Saturation: clamp the result to [-128, 127].
- Boundary cases:
  - All-zero input gives all-zero output, and r_valid still pulses.
  - Most-negative input CW value is handled without overflow.
  - i_valid asserted in the same cycle r_valid is high is not accepted (i_ready=0 in DONE); it is accepted one cycle later.

Decomposition:
- Shared package: CW/OW/FRAC defaults, the 8x8 cosine table as signed 14-bit constants, FSM state encoding (IDLE, CALC, DONE), accumulator width 40.
- Sub-module idct_coef_rom: combinational, input n[2:0], outputs the eight coefficients C[0..7][n]. It is shared by future 2-D IDCT row/column stages.

Test Plan:
- DC only: X0=181, X1..X7=0, accept -> after 8 clocks r_valid=1 and x0..x7 all 64; r_valid=0 next cycle.
- Single AC: X1=256, others 0 -> x0=126, x7=-126, antisymmetric (x[7-n] = -x[n] after rounding).
- Saturation: X0=1000 -> all outputs 127. X0=-1000 -> all outputs -128.
- Handshake:
  - i_valid held high continuously with changing vectors -> a vector is accepted only when i_ready=1, every 10 clocks.
  - Vectors presented during CALC/DONE are never reflected in the outputs.
- Reset mid-CALC: assert rst at n=4 -> outputs 0 and i_ready=1 immediately.
  - After release, no r_valid occurs.
  - A new X0=181 vector then yields all 64 with the normal latency.
- Round-trip: feed the forward DCT output for input (64,32,-45,55,64,-10,15,78) with the matching IN_SHIFT -> reconstructed samples within ±1 of the original.
